car_collision: RTL and testbench

Downstream consumer of the per-lane car x-positions produced by the car movers. It compares every car's grid cell against the frog's cell, decrements a life counter on a hit, and freezes play for a respawn interval. It then signals the frog controller to respawn, and ends the game when lives run out. It sits between the car/frog position sources and the top-level game-state/VGA logic.

---
 rtl/car_collision.sv | 156 +++++++++++++++
 tb/tb_car_collision.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/car_collision.sv
// rtl/car_collision.sv - car/frog collision detector with lives, respawn freeze and game over (optional grace period: CAR_COLLISION_INVULN_EN)
module car_collision #(
    parameter int NUM_CARS      = 4,
    parameter int GRID_W        = 20,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 12500000,
    parameter int INVULN_TICKS  = 25000000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [10*NUM_CARS-1:0] i_car_x,
    input  logic [5*NUM_CARS-1:0]  i_car_y,
    input  logic [9:0]            i_frog_x,
    input  logic [4:0]            i_frog_y,
    input  logic                  i_restart,
    output logic                  o_hit,
    output logic [1:0]            o_lives,
    output logic                  o_frozen,
    output logic                  o_respawn,
    output logic                  o_game_over,
    output logic                  o_invuln
);

    typedef enum logic [1:0] {
        S_PLAY      = 2'd0,
        S_RESPAWN   = 2'd1,
        S_GAME_OVER = 2'd2
    } state_t;

    localparam int             CNT_W      = $clog2(RESPAWN_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_TICKS - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

    if (LIVES < 1 || LIVES > 3 || RESPAWN_TICKS < 2 || INVULN_TICKS < 1) begin : g_bad_param
        $error("car_collision: illegal parameter value");
    end

    state_t           state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q, match_d;
    logic             hit_q, hit_d;
    logic             respawn_q, respawn_d;
    logic             invuln;

    // Any on-screen car sitting in the frog's cell; several matches collapse to one
    always_comb begin
        match_d = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (i_car_x[10*k +: 10] == i_frog_x &&
                i_car_y[5*k +: 5] == i_frog_y &&
                i_car_x[10*k +: 10] <= 10'(GRID_W)) begin
                match_d = 1'b1;
            end
        end
    end

    // Next-state logic: hit acceptance, freeze countdown, restart from game over
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        hit_d     = 1'b0;
        respawn_d = 1'b0;
        case (state_q)
            S_PLAY: begin
                if (match_q && !invuln) begin
                    hit_d = 1'b1;
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                        state_d = S_RESPAWN;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_GAME_OVER;
                    end
                end
            end
            S_RESPAWN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    respawn_d = 1'b1;
                    state_d   = S_PLAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (i_restart) begin
                    lives_d   = LIVES_INIT;
                    respawn_d = 1'b1;
                    state_d   = S_PLAY;
                end
            end
            default: state_d = S_PLAY;
        endcase
    end

    // Game state registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_PLAY;
            lives_q   <= LIVES_INIT;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            hit_q     <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            hit_q     <= hit_d;
            respawn_q <= respawn_d;
        end
    end

`ifdef CAR_COLLISION_INVULN_EN
    localparam int INV_W = $clog2(INVULN_TICKS + 1);

    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;

    assign invuln = (inv_cnt_q != '0);

    // Grace countdown armed by every respawn pulse, dropped on game over
    always_comb begin
        inv_cnt_d = inv_cnt_q;
        if (respawn_d) begin
            inv_cnt_d = INV_W'(INVULN_TICKS);
        end else if (state_d == S_GAME_OVER) begin
            inv_cnt_d = '0;
        end else if (invuln) begin
            inv_cnt_d = inv_cnt_q - 1'b1;
        end
    end

    // Grace counter register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            inv_cnt_q <= '0;
        end else begin
            inv_cnt_q <= inv_cnt_d;
        end
    end
`else
    assign invuln = 1'b0;
`endif

    assign o_hit       = hit_q;
    assign o_lives     = lives_q;
    assign o_frozen    = (state_q == S_RESPAWN);
    assign o_respawn   = respawn_q;
    assign o_game_over = (state_q == S_GAME_OVER);
    assign o_invuln    = invuln;

endmodule

// File: tb/tb_car_collision.sv
// tb/tb_car_collision.sv - directed self-checking bench for car_collision
module tb_car_collision;

    localparam int NC = 4;
`ifdef CAR_COLLISION_INVULN_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [10*NC-1:0] car_x;
    logic [5*NC-1:0]  car_y;
    logic [9:0]      frog_x;
    logic [4:0]      frog_y;
    logic            restart;
    logic            hit, frozen, respawn, game_over, invuln;
    logic [1:0]      lives;

    int checks = 0;
    int passes = 0;

    car_collision #(
        .NUM_CARS(NC), .GRID_W(20), .LIVES(3), .RESPAWN_TICKS(8), .INVULN_TICKS(16)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_car_x(car_x), .i_car_y(car_y),
        .i_frog_x(frog_x), .i_frog_y(frog_y), .i_restart(restart),
        .o_hit(hit), .o_lives(lives), .o_frozen(frozen), .o_respawn(respawn),
        .o_game_over(game_over), .o_invuln(invuln)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_car(input int k, input logic [9:0] x, input logic [4:0] y);
        car_x[10*k +: 10] = x;
        car_y[5*k +: 5]   = y;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // flags = {hit, frozen, respawn, game_over, invuln}
    function automatic logic [4:0] flags();
        return {hit, frozen, respawn, game_over, invuln};
    endfunction

    initial begin
        rst_n   = 1'b0;
        restart = 1'b0;
        frog_x  = 10'd10;
        frog_y  = 5'd14;
        for (int k = 0; k < NC; k++) set_car(k, 10'd10, 5'(3 + k));
        repeat (2) tick();
        check("reset_lives", lives, 3);
        check("reset_flags", flags(), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_lives", lives, 3);
            check("idle_flags", flags(), 0);
        end

        // Off-screen car on the frog's cell is not a collision
        frog_x = 10'd25;
        set_car(1, 10'd25, 5'd14);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("offscreen_hit", hit, 0);
        end
        set_car(1, 10'd10, 5'd4);
        frog_x = 10'd10;
        repeat (2) tick();

        // First hit: car 2, two-clock latency, 8-cycle freeze
        set_car(2, 10'd10, 5'd14);
        tick();
        check("hit1_early", hit, 0);
        tick();
        check("hit1_hit", hit, 1);
        check("hit1_lives", lives, 2);
        check("hit1_frozen", frozen, 1);
        set_car(2, 10'd10, 5'd5);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("hit1_frz_flags", {hit, frozen, respawn}, 3'b010);
        end
        tick();
        check("hit1_respawn", {frozen, respawn}, 2'b01);
        check("hit1_invuln", invuln, 32'(INV));
        check("hit1_lives_hold", lives, 2);
        tick();
        check("hit1_respawn_end", respawn, 0);
        repeat (20) tick();

        // Two cars matching at once count as one hit
        set_car(0, 10'd10, 5'd14);
        set_car(3, 10'd10, 5'd14);
        tick();
        tick();
        check("dbl_hit", hit, 1);
        check("dbl_lives", lives, 1);
        set_car(0, 10'd10, 5'd3);
        set_car(3, 10'd10, 5'd6);
        tick();
        check("dbl_hit_once", hit, 0);
        check("dbl_lives_once", lives, 1);
        repeat (6) tick();
        check("dbl_frozen_last", frozen, 1);
        tick();
        check("dbl_respawn", {frozen, respawn}, 2'b01);
        repeat (20) tick();

        // Last life lost at the right-edge cell x=GRID_W
        frog_x = 10'd20;
        set_car(1, 10'd20, 5'd14);
        tick();
        tick();
        check("go_hit", hit, 1);
        check("go_lives", lives, 0);
        check("go_state", {frozen, game_over}, 2'b01);
        tick();
        check("go_after", {hit, frozen, respawn, game_over}, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("go_ignore", flags(), 5'b00010);
            check("go_lives_hold", lives, 0);
        end

        // Restart from game over
        set_car(1, 10'd10, 5'd4);
        frog_x  = 10'd10;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rst_lives", lives, 3);
        check("rst_flags", flags(), {3'b001, 1'b0, INV});
        tick();
        check("rst_after", {hit, respawn, game_over}, 3'b000);
        repeat (20) tick();

        // Restart while playing does nothing
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("play_restart_flags", flags(), 0);
        check("play_restart_lives", lives, 3);
        tick();
        check("play_restart_after", respawn, 0);

        // Continuous match across a respawn
        set_car(2, 10'd10, 5'd14);
        tick();
        tick();
        check("cont_hit", hit, 1);
        check("cont_lives", lives, 2);
        repeat (7) tick();
        check("cont_frozen_last", frozen, 1);
        tick();
        check("cont_respawn", {hit, frozen, respawn}, 3'b001);
`ifdef CAR_COLLISION_INVULN_EN
        check("cont_inv_start", invuln, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("cont_inv_hold", {hit, invuln}, 2'b01);
        end
        tick();
        check("cont_inv_end", {hit, invuln}, 2'b00);
        tick();
        check("cont_hit2", hit, 1);
        check("cont_lives2", lives, 1);
`else
        tick();
        check("cont_hit2", hit, 1);
        check("cont_lives2", lives, 1);
        check("cont_noinv", invuln, 0);
`endif

        // Reset in the middle of a freeze
        repeat (3) tick();
        check("mid_frozen", frozen, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_lives", lives, 3);
        check("mid_rst_flags", flags(), 0);
        set_car(2, 10'd10, 5'd5);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_flags", flags(), 0);
            check("post_rst_lives", lives, 3);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
